bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
Round-robin arbiter that shares the system bus (ctrl/data/ack path to slaves such as the VGA slave interface) between up to NUM_MASTERS requesters.
- Grants exactly one master at a time, holds the grant while that master keeps its request asserted, and inserts a turnaround gap between owners.
- Preempts a master that exceeds a maximum tenure while other masters are waiting.
- Sits between the masters (CPU, DMA, etc.) and the bus mux; grant_idx drives the mux select.

Parameters:
NUM_MASTERS, 4, number of requesters (2..8)
IDX_WIDTH, 2, width of grant_idx; must satisfy 2**IDX_WIDTH >= NUM_MASTERS
MAX_HOLD, 64, maximum tenure in cycles before preemption when others are waiting (>=2)
HOLD_WIDTH, 7, hold counter width; must hold MAX_HOLD
TURN_CYCLES, 1, turnaround gap in cycles with no grant (>=1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req  input  NUM_MASTERS  per-master bus request, level, held for the whole transaction
grant  output  NUM_MASTERS  one-hot grant, registered
grant_idx  output  IDX_WIDTH  index of the current owner; valid only when bus_busy=1
bus_busy  output  1  high when any grant bit is high
preempt  output  1  one-cycle pulse when the owner is revoked by timeout

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE, grant=0, grant_idx=0, bus_busy=0, preempt=0, hold_cnt=0, last_owner=NUM_MASTERS-1 so master 0 has top priority after reset. Outputs clear immediately, including mid-transaction.
- All outputs are registered.
- States: IDLE, OWNED, TURN.
- IDLE:
  - If req!=0, select the first set bit searching upward from (last_owner+1) mod NUM_MASTERS, wrapping around.
  - Next cycle: state=OWNED, grant[sel]=1, grant_idx=sel, last_owner=sel, hold_cnt=1.
  - Latency from req sampled high in IDLE to grant high is 1 cycle.
- OWNED:
  - While req[owner]=1, hold_cnt increments and saturates at MAX_HOLD.
  - If req[owner]=0: next cycle grant=0, state=TURN, turn_cnt=1.
  - Else if hold_cnt==MAX_HOLD and some other req bit is set: next cycle grant=0, preempt=1 for that one cycle, state=TURN.
  - Else if hold_cnt==MAX_HOLD and no other request: the owner keeps the bus indefinitely. The counter stays saturated, so preemption fires as soon as another request appears.
- TURN:
  - grant=0 for exactly TURN_CYCLES cycles, then state=IDLE.
  - Requests arriving during TURN are not lost; they are evaluated in IDLE.
- Minimum idle gap between two owners is TURN_CYCLES+1 cycles (TURN plus the IDLE arbitration cycle).
- Simultaneous owner release and timeout expiry: treated as a normal release, preempt stays 0.
- A preempted master that still holds req competes normally. It has the lowest priority at the next arbitration because last_owner points to it.
- The same master re-requesting with no competitor is re-granted after the gap.
- req bits at or above NUM_MASTERS do not exist. grant never has more than one bit set; this is an assertion in the bench.

Decomposition:
- Shared package/header: state encodings (IDLE, OWNED, TURN) and the default NUM_MASTERS/MAX_HOLD/TURN_CYCLES constants, reused by the bus mux and the slave interfaces.
- One sub-module: rr_priority_pick. Combinational; inputs req and last_owner, outputs a found flag and the selected index. It holds the wrap-around search so it can be unit-tested separately.

Test Plan:
- Reset with req=4'b1111 → first grant=4'b0001 and grant_idx=0, one cycle after rst_n rises and the arbiter is in IDLE; all outputs 0 while rst_n=0.
- req=4'b1111 held, each master drops req after 3 owned cycles then re-raises it → grant sequence 0,1,2,3,0 with a 2-cycle gap between owners (TURN_CYCLES=1).
- Only master 2 requests, for 100 cycles → grant stays 4'b0100 throughout and preempt stays 0.
- Master 1 holds the bus while master 3 raises req at cycle 10 of tenure → preempt pulses once when hold_cnt reaches 64; grant=0 for 2 cycles; then grant=4'b1000.
- Master 0 drops req on the same cycle hold_cnt==MAX_HOLD while master 1 is waiting → preempt stays 0; master 1 is granted after the gap.
- rst_n asserted mid-tenure with grant=4'b0010 → grant, bus_busy and preempt go to 0 without waiting for a clock edge; after release, master 0 has top priority.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// Shared bus arbitration types and default sizing.
// Reused by the bus mux and slave interfaces.
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWNED = 2'd1,
    ST_TURN  = 2'd2
  } arb_state_e;

  localparam int DEF_NUM_MASTERS = 4;
  localparam int DEF_IDX_WIDTH   = 2;
  localparam int DEF_MAX_HOLD    = 64;
  localparam int DEF_HOLD_WIDTH  = 7;
  localparam int DEF_TURN_CYCLES = 1;

endpackage

// File: rtl/bus_arbiter_rr_priority_pick.sv
// Round-robin pick: first set request after last_owner,
// wrapping around.
module rr_priority_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_owner,
  output logic          found,
  output logic [IW-1:0] idx
);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= N; i++) begin
      if (!found &&
          (((req >> ((int'(last_owner) + i) % N))
            & N'(1)) != '0)) begin
        found = 1'b1;
        idx   = IW'((int'(last_owner) + i) % N);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with turnaround gap
// and tenure-limit preemption.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = DEF_NUM_MASTERS,
  parameter int IDX_WIDTH   = DEF_IDX_WIDTH,
  parameter int MAX_HOLD    = DEF_MAX_HOLD,
  parameter int HOLD_WIDTH  = DEF_HOLD_WIDTH,
  parameter int TURN_CYCLES = DEF_TURN_CYCLES
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_MASTERS-1:0] req,
  output logic [NUM_MASTERS-1:0] grant,
  output logic [IDX_WIDTH-1:0]   grant_idx,
  output logic                   bus_busy,
  output logic                   preempt
);

  localparam int TW = $clog2(TURN_CYCLES + 1);

  arb_state_e             r_state;
  logic [NUM_MASTERS-1:0] r_grant;
  logic [IDX_WIDTH-1:0]   r_idx;
  logic [IDX_WIDTH-1:0]   r_last;
  logic [HOLD_WIDTH-1:0]  r_hold;
  logic [TW-1:0]          r_turn;
  logic                   r_busy;
  logic                   r_preempt;

  logic                   w_found;
  logic [IDX_WIDTH-1:0]   w_sel;
  logic                   w_own_req;
  logic                   w_others;
  logic                   w_sat;

  rr_priority_pick #(
    .N  (NUM_MASTERS),
    .IW (IDX_WIDTH)
  ) u_pick (
    .req        (req),
    .last_owner (r_last),
    .found      (w_found),
    .idx        (w_sel)
  );

  // grant is one-hot, so masking by it isolates the owner
  assign w_own_req = |(req & r_grant);
  assign w_others  = |(req & ~r_grant);
  assign w_sat     = (r_hold == HOLD_WIDTH'(MAX_HOLD));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_grant   <= '0;
      r_idx     <= '0;
      r_last    <= IDX_WIDTH'(NUM_MASTERS - 1);
      r_hold    <= '0;
      r_turn    <= '0;
      r_busy    <= 1'b0;
      r_preempt <= 1'b0;
    end else begin
      r_preempt <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_state <= ST_OWNED;
            r_grant <= NUM_MASTERS'(1) << w_sel;
            r_idx   <= w_sel;
            r_last  <= w_sel;
            r_hold  <= HOLD_WIDTH'(1);
            r_busy  <= 1'b1;
          end
        end
        ST_OWNED: begin
          if (!w_own_req || (w_sat && w_others)) begin
            r_state   <= ST_TURN;
            r_grant   <= '0;
            r_busy    <= 1'b0;
            r_turn    <= TW'(1);
            r_preempt <= w_own_req;
          end else if (!w_sat) begin
            r_hold <= r_hold + HOLD_WIDTH'(1);
          end
        end
        ST_TURN: begin
          if (r_turn == TW'(TURN_CYCLES)) begin
            r_state <= ST_IDLE;
          end else begin
            r_turn <= r_turn + TW'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign grant     = r_grant;
  assign grant_idx = r_idx;
  assign bus_busy  = r_busy;
  assign preempt   = r_preempt;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: reset, rotation,
// solo tenure, preemption, release at limit, async reset.
module tb_bus_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       bus_busy;
  logic       preempt;

  int checks;
  int errors;

  bus_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .grant     (grant),
    .grant_idx (grant_idx),
    .bus_busy  (bus_busy),
    .preempt   (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    checks++;
    if (!$onehot0(grant)) begin
      errors++;
      $display("FAIL onehot grant=%b", grant);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] r);
    rst_n = 1'b0;
    req   = r;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 4'b1111;
    tick();
    tick();
    checks++;
    if ({grant, grant_idx, bus_busy, preempt} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outs got %b/%0d/%b/%b want 0",
               grant, grant_idx, bus_busy, preempt);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (grant !== 4'b0001 || grant_idx !== 2'd0 ||
        bus_busy !== 1'b1) begin
      errors++;
      $display("FAIL first_grant got %b/%0d/%b want 0001/0/1",
               grant, grant_idx, bus_busy);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp;
    do_reset(4'b1111);
    tick();
    for (int k = 0; k < 5; k++) begin
      exp = 4'b0001 << (k % 4);
      for (int s = 0; s < 3; s++) begin
        checks++;
        if (grant !== exp || grant_idx !== 2'(k % 4)) begin
          errors++;
          $display("FAIL rr_owner k=%0d got %b/%0d want %b/%0d",
                   k, grant, grant_idx, exp, k % 4);
        end
        if (s < 2) tick();
      end
      req = req & ~exp;
      tick();
      checks++;
      if (grant !== 4'b0000 || bus_busy !== 1'b0) begin
        errors++;
        $display("FAIL rr_gap1 k=%0d got %b want 0000", k, grant);
      end
      req = req | exp;
      tick();
      checks++;
      if (grant !== 4'b0000) begin
        errors++;
        $display("FAIL rr_gap2 k=%0d got %b want 0000", k, grant);
      end
      tick();
    end
  endtask

  task automatic test_solo_hold();
    do_reset(4'b0000);
    req = 4'b0100;
    tick();
    for (int t = 0; t < 100; t++) begin
      checks++;
      if (grant !== 4'b0100 || preempt !== 1'b0) begin
        errors++;
        $display("FAIL solo t=%0d got %b/%b want 0100/0",
                 t, grant, preempt);
      end
      tick();
    end
  endtask

  task automatic test_preempt();
    do_reset(4'b0000);
    req = 4'b0010;
    tick();
    repeat (9) tick();
    req = 4'b1010;
    for (int t = 0; t < 54; t++) begin
      tick();
      checks++;
      if (grant !== 4'b0010 || preempt !== 1'b0) begin
        errors++;
        $display("FAIL pre_hold t=%0d got %b/%b want 0010/0",
                 t, grant, preempt);
      end
    end
    tick();
    checks++;
    if (preempt !== 1'b1 || grant !== 4'b0000) begin
      errors++;
      $display("FAIL pre_pulse got %b/%b want 1/0000",
               preempt, grant);
    end
    tick();
    checks++;
    if (preempt !== 1'b0 || grant !== 4'b0000) begin
      errors++;
      $display("FAIL pre_gap got %b/%b want 0/0000",
               preempt, grant);
    end
    tick();
    checks++;
    if (grant !== 4'b1000 || grant_idx !== 2'd3) begin
      errors++;
      $display("FAIL pre_next got %b/%0d want 1000/3",
               grant, grant_idx);
    end
  endtask

  task automatic test_release_at_max();
    do_reset(4'b0000);
    req = 4'b0001;
    tick();
    req = 4'b0011;
    for (int t = 0; t < 63; t++) begin
      tick();
      checks++;
      if (grant !== 4'b0001 || preempt !== 1'b0) begin
        errors++;
        $display("FAIL rel_hold t=%0d got %b/%b want 0001/0",
                 t, grant, preempt);
      end
    end
    req = 4'b0010;
    for (int t = 0; t < 2; t++) begin
      tick();
      checks++;
      if (grant !== 4'b0000 || preempt !== 1'b0) begin
        errors++;
        $display("FAIL rel_gap t=%0d got %b/%b want 0000/0",
                 t, grant, preempt);
      end
    end
    tick();
    checks++;
    if (grant !== 4'b0010 || grant_idx !== 2'd1) begin
      errors++;
      $display("FAIL rel_next got %b/%0d want 0010/1",
               grant, grant_idx);
    end
  endtask

  task automatic test_async_reset();
    do_reset(4'b0000);
    req = 4'b0010;
    tick();
    tick();
    checks++;
    if (grant !== 4'b0010) begin
      errors++;
      $display("FAIL ar_pre got %b want 0010", grant);
    end
    req = 4'b1111;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({grant, grant_idx, bus_busy, preempt} !== 8'h00) begin
      errors++;
      $display("FAIL ar_clear got %b/%0d/%b/%b want 0",
               grant, grant_idx, bus_busy, preempt);
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (grant !== 4'b0001 || grant_idx !== 2'd0) begin
      errors++;
      $display("FAIL ar_prio got %b/%0d want 0001/0",
               grant, grant_idx);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    req    = 4'b0000;
    test_reset();
    test_round_robin();
    test_solo_hold();
    test_preempt();
    test_release_at_max();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
